// File: rtl/progress_tracker.sv
// Multi-channel check progress tracker.
// Counts completed checks per channel against TOT_CHECK and reports the
// quantised percentage, milestone pulses, per-channel and global done flags,
// a saturating failure count, an overflow flag and a stall watchdog.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset, highest priority
//   start_i      one-cycle pulse; clears all progress and enters RUN
//   chk_valid_i  per-channel check-completed strobe
//   chk_ok_i     per-channel pass(1)/fail(0), qualified by chk_valid_i
//   count_o      per-channel completed-check count, channel 0 in LSBs
//   pct_o        per-channel progress (7 bits each), floored to STEP_PCT
//   milestone_o  one-cycle pulse when a channel's pct_o changes
//   ch_done_o    channel reached TOT_CHECK (sticky)
//   all_done_o   all channels done (sticky until reset/start)
//   fail_cnt_o   total failed checks, saturating
//   overflow_o   sticky; a check arrived on a full channel or in DONE
//   stall_o      sticky; STALL_CYC consecutive idle cycles in RUN
//   busy_o       tracker is in RUN
module progress_tracker #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned TOT_CHECK = 1000,
    parameter int unsigned STEP_PCT  = 10,
    parameter int unsigned STALL_CYC = 4096,
    parameter int unsigned CNT_W     = $clog2(TOT_CHECK + 1),
    parameter bit          VERBOSE   = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [N_CH-1:0]         chk_valid_i,
    input  logic [N_CH-1:0]         chk_ok_i,
    output logic [N_CH*CNT_W-1:0]   count_o,
    output logic [N_CH*7-1:0]       pct_o,
    output logic [N_CH-1:0]         milestone_o,
    output logic [N_CH-1:0]         ch_done_o,
    output logic                    all_done_o,
    output logic [31:0]             fail_cnt_o,
    output logic                    overflow_o,
    output logic                    stall_o,
    output logic                    busy_o
);

    localparam int unsigned PW     = CNT_W + 7;
    localparam int unsigned N_STEP = 100 / STEP_PCT;
    localparam int unsigned SW     = $clog2(STALL_CYC + 1);
    localparam logic [CNT_W-1:0] TOT       = CNT_W'(TOT_CHECK);
    localparam logic [SW-1:0]    STALL_MAX = SW'(STALL_CYC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic [CNT_W-1:0]   count_q [N_CH];
    logic [6:0]         pct_q   [N_CH];
    logic [N_CH-1:0]    milestone_q;
    logic [N_CH-1:0]    ch_done_q;
    logic               all_done_q;
    logic [31:0]        fail_cnt_q;
    logic               overflow_q;
    logic               stall_q;
    logic [SW-1:0]      idle_q;

    logic [N_CH-1:0]    full_c;
    logic [N_CH-1:0]    accept_c;
    logic [N_CH-1:0]    bad_c;
    logic               ovf_hit_c;
    logic [6:0]         pct_calc_c [N_CH];
    logic [31:0]        fail_inc_c;
    logic [32:0]        fail_sum_c;
    logic [31:0]        fail_next_c;
    logic [SW-1:0]      idle_next_c;

    // Largest STEP_PCT multiple whose threshold the count has met; 100 is
    // reserved for an exactly complete channel.
    function automatic logic [6:0] pct_of(input logic [CNT_W-1:0] cnt);
        logic [PW-1:0] scaled;
        logic [6:0]    p;
        scaled = PW'(cnt) * PW'(100);
        p      = 7'd0;
        for (int unsigned k = 1; k < N_STEP; k++) begin
            if (scaled >= PW'(k * STEP_PCT) * PW'(TOT_CHECK)) begin
                p = 7'(k * STEP_PCT);
            end
        end
        if (cnt == TOT) begin
            p = 7'd100;
        end
        return p;
    endfunction

    // Acceptance, overflow detection, pct and failure-count arithmetic.
    always_comb begin
        full_c     = '0;
        accept_c   = '0;
        bad_c      = '0;
        fail_inc_c = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            full_c[c]     = (count_q[c] == TOT);
            accept_c[c]   = (state_q == RUN) && chk_valid_i[c] && !full_c[c];
            bad_c[c]      = accept_c[c] && !chk_ok_i[c];
            fail_inc_c    = fail_inc_c + 32'(bad_c[c]);
            pct_calc_c[c] = pct_of(count_q[c]);
        end
        // A full channel counts as done here, which also covers the one
        // cycle before its ch_done flag registers.
        ovf_hit_c   = ((state_q == RUN)  && ((chk_valid_i & full_c) != '0)) ||
                      ((state_q == DONE) && (chk_valid_i != '0));
        fail_sum_c  = {1'b0, fail_cnt_q} + {1'b0, fail_inc_c};
        fail_next_c = fail_sum_c[32] ? '1 : fail_sum_c[31:0];
        idle_next_c = (idle_q == STALL_MAX) ? idle_q : idle_q + SW'(1);
    end

    // Control FSM and all tracked state.
    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            state_q     <= rst_i ? IDLE : RUN;
            busy_q      <= !rst_i;
            for (int c = 0; c < int'(N_CH); c++) begin
                count_q[c] <= '0;
                pct_q[c]   <= '0;
            end
            milestone_q <= '0;
            ch_done_q   <= '0;
            all_done_q  <= 1'b0;
            fail_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            stall_q     <= 1'b0;
            idle_q      <= '0;
        end else begin
            for (int c = 0; c < int'(N_CH); c++) begin
                pct_q[c]       <= pct_calc_c[c];
                milestone_q[c] <= (pct_calc_c[c] != pct_q[c]);
                if (pct_calc_c[c] == 7'd100) begin
                    ch_done_q[c] <= 1'b1;
                end
                if (accept_c[c]) begin
                    count_q[c] <= count_q[c] + CNT_W'(1);
                end
            end
            if (&ch_done_q) begin
                all_done_q <= 1'b1;
            end
            fail_cnt_q <= fail_next_c;
            if (ovf_hit_c) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                RUN: begin
                    // Stall watchdog: consecutive cycles with no strobe at all.
                    if (chk_valid_i == '0) begin
                        idle_q <= idle_next_c;
                        if (idle_next_c == STALL_MAX) begin
                            stall_q <= 1'b1;
                        end
                    end else begin
                        idle_q <= '0;
                    end
                    if (&ch_done_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_out
        assign count_o[g*CNT_W +: CNT_W] = count_q[g];
        assign pct_o[g*7 +: 7]           = pct_q[g];
    end

    assign milestone_o = milestone_q;
    assign ch_done_o   = ch_done_q;
    assign all_done_o  = all_done_q;
    assign fail_cnt_o  = fail_cnt_q;
    assign overflow_o  = overflow_q;
    assign stall_o     = stall_q;
    assign busy_o      = busy_q;

`ifndef SYNTHESIS
    // Progress messages for interactive runs.
    if (VERBOSE) begin : g_verbose
        always_ff @(posedge clk_i) begin
            if (!rst_i && !start_i) begin
                for (int c = 0; c < int'(N_CH); c++) begin
                    if (pct_calc_c[c] != pct_q[c]) begin
                        $display("ch%0d: %0d%% completed...", c, pct_calc_c[c]);
                    end
                end
                if ((&ch_done_q) && !all_done_q) begin
                    $display("ALL DONE");
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_progress_tracker.sv
// Randomised self-checking bench for progress_tracker against a
// transaction-level model of per-channel counts and derived progress.
module tb_progress_tracker;

    localparam int N_CH  = 4;
    localparam int TOT   = 40;
    localparam int STEP  = 10;
    localparam int STALL = 16;
    localparam int CNT_W = $clog2(TOT + 1);

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic                  start_i;
    logic [N_CH-1:0]       chk_valid_i;
    logic [N_CH-1:0]       chk_ok_i;
    logic [N_CH*CNT_W-1:0] count_o;
    logic [N_CH*7-1:0]     pct_o;
    logic [N_CH-1:0]       milestone_o;
    logic [N_CH-1:0]       ch_done_o;
    logic                  all_done_o;
    logic [31:0]           fail_cnt_o;
    logic                  overflow_o;
    logic                  stall_o;
    logic                  busy_o;

    progress_tracker #(
        .N_CH      (N_CH),
        .TOT_CHECK (TOT),
        .STEP_PCT  (STEP),
        .STALL_CYC (STALL),
        .CNT_W     (CNT_W),
        .VERBOSE   (1'b0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .chk_valid_i (chk_valid_i),
        .chk_ok_i    (chk_ok_i),
        .count_o     (count_o),
        .pct_o       (pct_o),
        .milestone_o (milestone_o),
        .ch_done_o   (ch_done_o),
        .all_done_o  (all_done_o),
        .fail_cnt_o  (fail_cnt_o),
        .overflow_o  (overflow_o),
        .stall_o     (stall_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: phase 0 idle, 1 running, 2 finished.
    int     m_phase;
    int     m_cnt  [N_CH];
    int     m_pct  [N_CH];
    bit     m_ms   [N_CH];
    bit     m_done [N_CH];
    bit     m_all, m_ovf, m_stall;
    longint m_fail;
    int     m_idle;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_pct(input int n);
        if (n == TOT) return 100;
        return (n * 100 / (STEP * TOT)) * STEP;
    endfunction

    task automatic model_clear(input int phase);
        m_phase = phase;
        for (int c = 0; c < N_CH; c++) begin
            m_cnt[c] = 0; m_pct[c] = 0; m_ms[c] = 0; m_done[c] = 0;
        end
        m_all = 0; m_ovf = 0; m_stall = 0; m_fail = 0; m_idle = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input logic [N_CH-1:0] v,
                              input logic [N_CH-1:0] ok);
        bit all_before;
        if (r) begin
            model_clear(0);
        end else if (s) begin
            model_clear(1);
        end else begin
            all_before = 1;
            for (int c = 0; c < N_CH; c++) all_before &= m_done[c];
            // progress reflects the count as it stood before this cycle
            for (int c = 0; c < N_CH; c++) begin
                int np;
                np = exp_pct(m_cnt[c]);
                m_ms[c]  = (np != m_pct[c]);
                m_pct[c] = np;
                if (np == 100) m_done[c] = 1;
            end
            if (all_before) m_all = 1;
            if (m_phase == 1) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (v[c]) begin
                        if (m_cnt[c] == TOT) begin
                            m_ovf = 1;
                        end else begin
                            m_cnt[c]++;
                            if (!ok[c] && m_fail < 64'hFFFF_FFFF) m_fail++;
                        end
                    end
                end
                if (v == 0) begin
                    if (m_idle < STALL) m_idle++;
                    if (m_idle == STALL) m_stall = 1;
                end else begin
                    m_idle = 0;
                end
                if (all_before) m_phase = 2;
            end else if (m_phase == 2) begin
                if (v != 0) m_ovf = 1;
            end
        end
    endtask

    task automatic compare_all();
        logic [N_CH-1:0] ms_e, done_e;
        for (int c = 0; c < N_CH; c++) begin
            ms_e[c]   = m_ms[c];
            done_e[c] = m_done[c];
            check($sformatf("count%0d", c), 64'(count_o[c*CNT_W +: CNT_W]), 64'(m_cnt[c]));
            check($sformatf("pct%0d", c), 64'(pct_o[c*7 +: 7]), 64'(m_pct[c]));
        end
        check("milestone", 64'(milestone_o), 64'(ms_e));
        check("ch_done", 64'(ch_done_o), 64'(done_e));
        check("all_done", 64'(all_done_o), 64'(m_all));
        check("fail_cnt", 64'(fail_cnt_o), 64'(m_fail));
        check("overflow", 64'(overflow_o), 64'(m_ovf));
        check("stall", 64'(stall_o), 64'(m_stall));
        check("busy", 64'(busy_o), 64'(m_phase == 1));
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input bit r, input bit s, input logic [N_CH-1:0] v,
                        input logic [N_CH-1:0] ok);
        rst_i = r; start_i = s; chk_valid_i = v; chk_ok_i = ok;
        model_step(r, s, v, ok);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [N_CH-1:0] rand_bits(input int pct);
        logic [N_CH-1:0] b;
        for (int c = 0; c < N_CH; c++) b[c] = ($urandom_range(0, 99) < pct);
        return b;
    endfunction

    initial begin
        int prob [N_CH];
        int iter;
        int dens;
        rst_i = 1; start_i = 0; chk_valid_i = '0; chk_ok_i = '0;
        model_clear(0);
        prob[0] = 95; prob[1] = 75; prob[2] = 60; prob[3] = 50;

        // reset held, then strobes ignored while idle
        repeat (3) step(1, 0, '0, '0);
        repeat (5) step(0, 0, 4'b0001, 4'b0000);

        // full run to completion with skewed channel rates and some failures
        step(0, 1, '0, '0);
        iter = 0;
        while (m_phase != 2 && iter < 2000) begin
            logic [N_CH-1:0] v;
            for (int c = 0; c < N_CH; c++) v[c] = ($urandom_range(0, 99) < prob[c]);
            step(0, 0, v, rand_bits(85));
            iter++;
        end
        check("all_done_reached", 64'(all_done_o), 64'(1));
        check("done_fail_cnt_nonzero", 64'(fail_cnt_o != 0), 64'(1));
        repeat (4) step(0, 0, rand_bits(50), rand_bits(50));

        // stall in RUN, then restart clears everything
        step(0, 1, '0, '0);
        repeat (6) step(0, 0, rand_bits(60), rand_bits(80));
        repeat (STALL + 3) step(0, 0, '0, '0);
        check("stall_set", 64'(stall_o), 64'(1));
        step(0, 1, '0, '0);
        check("restart_busy", 64'(busy_o), 64'(1));
        repeat (3) step(0, 0, '0, '0);

        // reset in the middle of a run
        repeat (30) step(0, 0, rand_bits(70), rand_bits(80));
        step(1, 0, '0, '0);
        check("mid_rst_busy", 64'(busy_o), 64'(0));
        repeat (2) step(0, 0, rand_bits(50), rand_bits(50));

        // long random mix with occasional restarts, resets and idle bursts
        dens = 50;
        for (int i = 0; i < 6000; i++) begin
            bit r, s;
            if (i % 64 == 0) begin
                case ($urandom_range(0, 4))
                    0: dens = 0;
                    1: dens = 10;
                    2: dens = 50;
                    default: dens = 90;
                endcase
            end
            r = ($urandom_range(0, 999) < 3);
            s = ($urandom_range(0, 999) < 8) || (m_phase == 0 && $urandom_range(0, 9) == 0);
            step(r, s, rand_bits(dens), rand_bits(80));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/progress_tracker.md
Name: progress_tracker

Overview:
- Synthesisable, multi-channel successor to the bench progress display.
- Counts completed checks per channel against a per-channel total and reports quantised percentage progress, milestone pulses, failures, overflow and stall.
- Sits in the verification environment beside the checkers/scoreboards. Feeds end-of-test logic and optional `$display` reporting.

Parameters:
- N_CH, 4, number of independent check channels (>=1)
- TOT_CHECK, 1000, expected checks per channel (>=1)
- STEP_PCT, 10, milestone granularity in percent (1..100, must divide 100)
- STALL_CYC, 4096, cycles without any check while running before stall is flagged (>=1)
- CNT_W, $clog2(TOT_CHECK+1), derived width of per-channel counters
- VERBOSE, 1, when 1 the simulation-only milestone `$display` is enabled

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  arms tracker; one-cycle pulse
- chk_valid_i  in  N_CH  per-channel check-completed strobe, one check per set bit per cycle
- chk_ok_i  in  N_CH  per-channel pass(1)/fail(0), qualified by chk_valid_i
- count_o  out  N_CH*CNT_W  per-channel completed-check count, channel 0 in LSBs
- pct_o  out  N_CH*7  per-channel progress, floored to a STEP_PCT multiple (0..100)
- milestone_o  out  N_CH  one-cycle pulse when that channel's pct_o increases
- ch_done_o  out  N_CH  channel reached TOT_CHECK (sticky)
- all_done_o  out  1  all channels done (sticky until reset/start)
- fail_cnt_o  out  32  total failed checks, all channels, saturating
- overflow_o  out  1  sticky; a check arrived on a done channel
- stall_o  out  1  sticky; STALL_CYC idle cycles in RUN
- busy_o  out  1  state == RUN

Behaviour:
- Reset (rst_i=1 at a clock edge): all outputs and counters 0, state IDLE. Reset mid-run discards all progress. Reset has priority over every other input.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start_i. Counters, pct, flags and fail_cnt are cleared in the same cycle.
  - RUN -> DONE the cycle after all ch_done are 1.
  - DONE -> RUN on start_i, with the same clear.
  - start_i while in RUN restarts: same clear, stays RUN.
- Check acceptance:
  - chk_valid_i is ignored in IDLE.
  - chk_valid_i in DONE, or on a channel whose ch_done is set, does not increment the count and sets overflow_o.
- Counter update:
  - In RUN, count[c] increments by 1 on chk_valid_i[c] when count[c] < TOT_CHECK. Visible on count_o the next cycle.
  - Channels update independently; simultaneous strobes on all channels are all accepted.
- fail_cnt:
  - Adds popcount(chk_valid_i & ~chk_ok_i & accepted) per cycle.
  - Saturates at 2^32-1.
  - Overflowed checks are not counted.
- pct computation:
  - Integer only, no reals: pct[c] = largest k*STEP_PCT with count[c]*100 >= k*STEP_PCT*TOT_CHECK.
  - Products are computed at CNT_W+7 bits, no truncation.
  - pct_o is registered, updating the cycle after count_o changes (latency 2 from strobe).
  - pct reaches 100 exactly when count == TOT_CHECK. It never reaches 100 earlier, even where floor rounding would give it.
- milestone_o[c] pulses for 1 cycle whenever pct[c] changes.
  - No pulse for reset or start clears.
  - If several steps are crossed in one update (TOT_CHECK < 100/STEP_PCT), one pulse is issued and pct jumps to the new value.
- ch_done_o[c] asserts the same cycle pct_o[c] becomes 100.
- all_done_o is the registered AND of ch_done, one cycle after the last ch_done. It remains asserted in DONE.
- Stall watchdog:
  - Runs only in RUN.
  - Counts cycles with chk_valid_i == 0 and resets on any valid bit.
  - When the count reaches STALL_CYC, stall_o is set. It is sticky until reset/start, and the FSM stays in RUN.
- Simulation only (VERBOSE, translate_off): on each milestone pulse, print "ch<c>: <pct>% completed..."; print "ALL DONE" on the rising edge of all_done_o.

Test Plan:
- Reset/idle: rst_i held 3 cycles, then 5 strobes on ch0 while in IDLE -> count_o=0, pct_o=0, no milestone, busy_o=0.
- Single channel sweep, TOT_CHECK=1000, STEP_PCT=10: start, 1000 strobes ch0 -> exactly 10 milestone pulses at counts 100,200..1000; pct_o=100 and ch_done_o[0]=1 two cycles after the 1000th strobe.
- Concurrency, N_CH=4: all four channels strobed every cycle for 1000 cycles, ch2 chk_ok=0 on 7 strobes -> all_done_o one cycle after ch_done=4'hF, fail_cnt_o=7, state DONE.
- Coarse total, TOT_CHECK=3, STEP_PCT=10: 3 strobes ch0 -> pct_o sequence 30, 60, 100; one pulse per update. No 100 before the 3rd strobe.
- Overflow: channel done, 2 extra strobes -> count_o stays 1000, overflow_o=1, fail_cnt_o unchanged.
- Stall and restart: STALL_CYC=16, idle 16 cycles in RUN -> stall_o=1; then start_i -> all outputs cleared, busy_o=1. rst_i asserted mid-run after 500 checks -> all outputs 0 the next cycle.
